// File: rtl/load_store_unit.sv
// Handshaked load/store unit: byte-lane alignment, sign/zero extension and
// optional two-beat splitting of word-crossing accesses onto a valid/ready memory port.
module load_store_unit #(
  parameter int XLEN           = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  rsp_valid,
  output logic [XLEN-1:0]       rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN/8-1:0]     mem_be,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rdata
);
  localparam int NB   = XLEN / 8;
  localparam int NB2  = 2 * NB;
  localparam int OFFW = $clog2(NB);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ0  = 3'd1;
  localparam logic [2:0] S_WAIT0 = 3'd2;
  localparam logic [2:0] S_REQ1  = 3'd3;
  localparam logic [2:0] S_WAIT1 = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  function automatic logic crosses(input logic [OFFW-1:0] off, input logic [1:0] size);
    return (5'(off) + (5'd1 << size)) > 5'(NB);
  endfunction

  logic [2:0]            state_q, state_d;
  logic                  we_q, sgn_q, err_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]       wdata_q, rd0_q, rd1_q;

  logic                  accept, err_in, cross_w;
  logic [OFFW-1:0]       off_w;
  logic [3:0]            bytes_w;
  logic [NB2-1:0]        be_full;
  logic [2*XLEN-1:0]     wd_full;
  logic [ADDR_WIDTH-1:0] base_w;
  logic [XLEN-1:0]       asm_w, ext_w;

  assign accept = req_valid && (state_q == S_IDLE);
  // Decided from the live request so an error reaches RESP on the very next cycle.
  assign err_in = (req_size == 2'd3 && XLEN == 32) ||
                  (!MISALIGN_SPLIT && crosses(req_addr[OFFW-1:0], req_size));

  assign off_w   = addr_q[OFFW-1:0];
  assign bytes_w = 4'd1 << size_q;
  assign cross_w = crosses(off_w, size_q);
  assign base_w  = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
  // Low half of the shifted mask/data is beat 0, high half is beat 1.
  assign be_full = NB2'((9'd1 << bytes_w) - 9'd1) << off_w;
  assign wd_full = {{XLEN{1'b0}}, wdata_q} << {off_w, 3'b000};
  assign asm_w   = XLEN'({rd1_q, rd0_q} >> {off_w, 3'b000});

  always_comb begin
    logic topbit;
    topbit = 1'b0;
    ext_w  = '0;
    for (int i = 0; i < NB; i++)
      if (i == int'(bytes_w) - 1) topbit = asm_w[8*i+7];
    for (int i = 0; i < NB; i++)
      ext_w[8*i +: 8] = (i < int'(bytes_w)) ? asm_w[8*i +: 8] : {8{sgn_q & topbit}};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid)     state_d = err_in ? S_RESP : S_REQ0;
      S_REQ0:  if (mem_req_ready) state_d = S_WAIT0;
      S_WAIT0: if (mem_rsp_valid) state_d = cross_w ? S_REQ1 : S_RESP;
      S_REQ1:  if (mem_req_ready) state_d = S_WAIT1;
      S_WAIT1: if (mem_rsp_valid) state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        sgn_q   <= req_signed;
        err_q   <= err_in;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == S_WAIT0 && mem_rsp_valid) rd0_q <= mem_rdata;
      if (state_q == S_WAIT1 && mem_rsp_valid) rd1_q <= mem_rdata;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ0) || (state_q == S_REQ1);
  assign mem_we        = mem_req_valid && we_q;
  assign mem_addr      = (state_q == S_REQ1) ? base_w + ADDR_WIDTH'(NB) :
                         (state_q == S_REQ0) ? base_w : '0;
  assign mem_be        = (state_q == S_REQ1) ? be_full[NB2-1:NB] :
                         (state_q == S_REQ0) ? be_full[NB-1:0] : '0;
  assign mem_wdata     = (state_q == S_REQ1) ? wd_full[2*XLEN-1:XLEN] :
                         (state_q == S_REQ0) ? wd_full[XLEN-1:0] : '0;
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_err       = rsp_valid && err_q;
  assign rsp_rdata     = (rsp_valid && !we_q && !err_q) ? ext_w : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: byte-addressed memory responder plus a
// byte-level reference memory that predicts every load/store result.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  // second instance: no splitting; memory always ready and always answering
  logic        n_req_valid = 1'b0, n_req_ready, n_req_we = 1'b0, n_req_signed = 1'b0;
  logic [1:0]  n_req_size = 2'd0;
  logic [31:0] n_req_addr = '0;
  logic        n_rsp_valid, n_rsp_err, n_mem_req_valid, n_mem_we;
  logic [31:0] n_rsp_rdata, n_mem_addr, n_mem_wdata;
  logic [3:0]  n_mem_be;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .ADDR_WIDTH(32), .MISALIGN_SPLIT(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata));

  load_store_unit #(.XLEN(32), .ADDR_WIDTH(32), .MISALIGN_SPLIT(1'b0)) dut_ns (
    .clk(clk), .reset_n(reset_n),
    .req_valid(n_req_valid), .req_ready(n_req_ready), .req_we(n_req_we), .req_size(n_req_size),
    .req_signed(n_req_signed), .req_addr(n_req_addr), .req_wdata(32'h0),
    .rsp_valid(n_rsp_valid), .rsp_rdata(n_rsp_rdata), .rsp_err(n_rsp_err),
    .mem_req_valid(n_mem_req_valid), .mem_req_ready(1'b1), .mem_we(n_mem_we),
    .mem_addr(n_mem_addr), .mem_be(n_mem_be), .mem_wdata(n_mem_wdata),
    .mem_rsp_valid(1'b1), .mem_rdata(32'h12345678));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- memories ----------------
  logic [7:0] dmem    [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] init_b(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] rd_dmem(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : init_b(a);
  endfunction
  function automatic logic [7:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_b(a);
  endfunction

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      dmem[a + 32'(i)]    = w[8*i +: 8];
      ref_mem[a + 32'(i)] = w[8*i +: 8];
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    int nb;
    logic [31:0] v;
    nb = 1 << sz;
    v  = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = rd_ref(a + 32'(i));
    if (sg && v[8*nb-1]) for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // ---------------- memory responder ----------------
  logic        pend = 1'b0, force_stray = 1'b0, rdy_rand = 1'b0, stray_en = 1'b0;
  int          pcnt = 0, rsp_delay = 1, stall_n = 0, beats = 0;
  logic [31:0] prd;
  logic        held = 1'b0;
  logic [36:0] h_ctl;
  logic [31:0] h_wd;
  logic [31:0] lg_addr[$], lg_wd[$];
  logic [3:0]  lg_be[$];

  initial begin
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (pend) begin
        pcnt--;
        if (pcnt <= 0) begin mem_rsp_valid = 1'b1; mem_rdata = prd; pend = 1'b0; end
      end else if (force_stray || (stray_en && $urandom_range(0, 4) == 0)) begin
        mem_rsp_valid = 1'b1; mem_rdata = $urandom; force_stray = 1'b0;
      end
      if (held) begin
        chk("hold_ctl", {mem_req_valid, mem_be, mem_addr}, h_ctl);
        chk("hold_wdata", mem_wdata, h_wd);
      end
      held = 1'b0;
      if (stall_n > 0 && mem_req_valid) begin mem_req_ready = 1'b0; stall_n--; end
      else mem_req_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (mem_req_valid && !mem_req_ready) begin
        held = 1'b1; h_ctl = {mem_req_valid, mem_be, mem_addr}; h_wd = mem_wdata;
      end
      if (mem_req_valid && mem_req_ready) begin
        beats++;
        chk("beat_align", {62'd0, mem_addr[1:0]}, 64'd0);
        lg_addr.push_back(mem_addr); lg_be.push_back(mem_be); lg_wd.push_back(mem_wdata);
        for (int i = 0; i < 4; i++) prd[8*i +: 8] = rd_dmem(mem_addr + 32'(i));
        if (mem_we)
          for (int i = 0; i < 4; i++) if (mem_be[i]) dmem[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
        pend = 1'b1;
        pcnt = rdy_rand ? $urandom_range(1, 3) : rsp_delay;
      end
    end
  end

  // ---------------- request drivers ----------------
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    chk("req_ready", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 60) begin @(negedge clk); lat++; end
    if (!rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
    rd = rsp_rdata; er = rsp_err;
  endtask

  task automatic do_ns(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       output logic [31:0] rd, output logic er, output int lat, output int nb);
    @(negedge clk);
    n_req_valid = 1'b1; n_req_size = sz; n_req_signed = sg; n_req_addr = a;
    @(negedge clk);
    n_req_valid = 1'b0;
    lat = 1; nb = 0;
    while (!n_rsp_valid && lat < 60) begin
      if (n_mem_req_valid) nb++;
      @(negedge clk); lat++;
    end
    if (!n_rsp_valid) chk("ns_timeout", 64'd0, 64'd1);
    rd = n_rsp_rdata; er = n_rsp_err;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd, a, wd, exp_rd;
    logic        er, we, sg, v;
    logic [1:0]  sz;
    int          lat, nb, b0, exp_beats;

    repeat (3) @(negedge clk);
    chk("rst_outs", {req_ready, mem_req_valid, rsp_valid, rsp_err, mem_be}, {4'b1000, 4'h0});
    chk("rst_data", {mem_addr, rsp_rdata}, 64'd0);
    reset_n = 1'b1;

    // aligned word load, latency 3
    put_word(32'h100, 32'hDEADBEEF);
    lg_addr.delete(); lg_be.delete(); lg_wd.delete();
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, er, lat);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_lat", lat, 3);
    chk("lw_beat", {lg_addr[0], 28'd0, lg_be[0]}, {32'h100, 32'hF});

    // byte load sign / zero
    put_word(32'h100, 32'h80FFFFFF);
    lg_be.delete();
    do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, rd, er, lat);
    chk("lb_s", rd, 32'hFFFFFF80);
    chk("lb_be", lg_be[0], 4'h8);
    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, rd, er, lat);
    chk("lbu", rd, 32'h00000080);

    // split store
    lg_addr.delete(); lg_be.delete(); lg_wd.delete();
    do_req(1'b1, 2'd2, 1'b0, 32'h102, 32'h11223344, rd, er, lat);
    chk("sw_nbeats", lg_addr.size(), 2);
    chk("sw_b0", {lg_addr[0], 28'd0, lg_be[0]}, {32'h100, 32'hC});
    chk("sw_b0_wd", lg_wd[0], 32'h33440000);
    chk("sw_b1", {lg_addr[1], 28'd0, lg_be[1]}, {32'h104, 32'h3});
    chk("sw_b1_wd", lg_wd[1], 32'h00001122);
    chk("sw_lat", lat, 5);
    chk("sw_rsp", {31'd0, er, rd}, 64'd0);
    for (int i = 0; i < 4; i++) ref_mem[32'h102 + 32'(i)] = 8'(32'h11223344 >> (8*i));

    // split signed halfword load
    put_word(32'h200, 32'hAB000000);
    put_word(32'h204, 32'h000000CD);
    do_req(1'b0, 2'd1, 1'b1, 32'h203, 32'h0, rd, er, lat);
    chk("lh_split", {31'd0, er, rd}, {32'd0, 32'hFFFFCDAB});
    chk("lh_split_lat", lat, 5);

    // illegal size
    b0 = beats;
    do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, rd, er, lat);
    chk("sz3_err", {31'd0, er, rd}, {32'd1, 32'd0});
    chk("sz3_lat", lat, 1);
    chk("sz3_beats", beats - b0, 0);

    // backpressure
    stall_n = 5;
    do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, rd, er, lat);
    chk("bp_data", rd, 32'hAB000000);
    chk("bp_lat", lat, 8);

    // no-split instance
    do_ns(2'd2, 1'b0, 32'h101, rd, er, lat, nb);
    chk("ns_err", {31'd0, er, rd}, {32'd1, 32'd0});
    chk("ns_err_lat", {lat, nb}, {32'd1, 32'd0});
    do_ns(2'd2, 1'b0, 32'h100, rd, er, lat, nb);
    chk("ns_lw", {31'd0, er, rd}, {32'd0, 32'h12345678});
    chk("ns_lw_lat", {lat, nb}, {32'd3, 32'd1});
    do_ns(2'd1, 1'b0, 32'h101, rd, er, lat, nb);
    chk("ns_lh_mis", {31'd0, er, rd}, {32'd0, 32'h00003456});
    chk("ns_lh_beats", nb, 1);
    do_ns(2'd0, 1'b1, 32'h103, rd, er, lat, nb);
    chk("ns_lb", rd, 32'h00000012);

    // reset while waiting for the second beat
    b0 = beats;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h302;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 40 && beats < b0 + 1; i++) @(negedge clk);
    rsp_delay = 20;
    for (int i = 0; i < 40 && beats < b0 + 2; i++) @(negedge clk);
    chk("abort_beats", beats - b0, 2);
    @(posedge clk); #2;
    chk("in_wait1", {61'd0, req_ready, mem_req_valid, rsp_valid}, 64'd0);
    reset_n = 1'b0;
    #1;
    chk("abort_outs", {req_ready, mem_req_valid, rsp_valid, rsp_err, mem_be}, {4'b1000, 4'h0});
    chk("abort_addr", mem_addr, 32'd0);
    pend = 1'b0; rsp_delay = 1;
    @(negedge clk);
    reset_n = 1'b1;
    force_stray = 1'b1;
    v = 1'b0;
    repeat (4) begin @(negedge clk); v = v | rsp_valid; end
    chk("stray_rsp", v, 1'b0);
    chk("post_rst_ready", req_ready, 1'b1);

    // randomized traffic against the byte-level reference
    rdy_rand = 1'b1; stray_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sg = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15))
                                       : 32'($urandom_range(0, 63));
      wd = $urandom;
      exp_rd = '0;
      if (sz == 2'd3) exp_beats = 0;
      else exp_beats = (int'(a[1:0]) + (1 << sz) > 4) ? 2 : 1;
      if (sz != 2'd3) begin
        if (we) for (int i = 0; i < (1 << sz); i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
        else    exp_rd = ref_load(a, sz, sg);
      end
      b0 = beats;
      do_req(we, sz, sg, a, wd, rd, er, lat);
      chk("rnd_err", er, sz == 2'd3);
      chk("rnd_rdata", rd, exp_rd);
      chk("rnd_beats", beats - b0, exp_beats);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
